// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg -- shared types and constants for the modulo counter.
//   dir_e   : count direction (DIR_UP = 0, DIR_DOWN = 1)
//   mode_e  : MODE_WRAP free-runs, MODE_ONESHOT halts at the terminal count
//   state_e : counter FSM states RUN / HALT
package mod_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Number of distinct values a w-bit register can hold, as a 64-bit value
  // so that w = 32 does not overflow.
  function automatic logic [63:0] full_range(input int w);
    return 64'd1 << w;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// mod_counter_prescaler -- divides the enable stream so that tick_o fires on
// every PRESCALE-th cycle in which enb_i is high.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   restart_i : synchronous restart (counter clear or load), same effect as reset
//   enb_i     : enable; only enabled cycles advance the prescaler
//   tick_o    : combinational tick, high in the PRESCALE-th enabled cycle
module mod_counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic enb_i,
  output logic tick_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter_prescaler: PRESCALE must be >= 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = enb_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (enb_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter -- up/down modulo-MODULUS counter with wrap or one-shot mode.
// Optional prescaler compiled in with `define MOD_COUNTER_PRESCALE_EN
// (adds parameter PRESCALE); without it every enb cycle is a tick.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (count 0, RUN, done 0)
//   enb        : count enable
//   dir        : 0 count up, 1 count down
//   mode       : 0 wrap, 1 one-shot (halt at terminal count)
//   clear      : synchronous clear to 0, releases HALT
//   load       : synchronous load of load_value (clamped to MODULUS-1)
//   load_value : value taken on load
//   count      : registered count
//   carryout   : combinational terminal pulse, cascadable to a downstream enb
//   done       : registered, high while halted in one-shot
//   state_o    : debug view of the FSM state
// Priority each cycle: rst > clear > load > tick.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
`ifdef MOD_COUNTER_PRESCALE_EN
  ,
  parameter int              PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             dir,
  input  logic             mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carryout,
  output logic             done,
  output state_e           state_o
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > full_range(WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM_UP    = WIDTH'(MODULUS - 64'd1);
  // A full-range modulus wraps by plain register overflow.
  localparam bit               FULL_RANGE = (MODULUS == full_range(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;

`ifdef MOD_COUNTER_PRESCALE_EN
  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i     (clk),
    .rst_i     (rst),
    .restart_i (clear | load),
    .enb_i     (enb),
    .tick_o    (tick)
  );
`else
  assign tick = enb;
`endif

  // Terminal follows the live dir input, so a direction change takes effect
  // on the very next tick without touching the count.
  assign at_term  = (dir == DIR_DOWN) ? (count_q == '0) : (count_q == TERM_UP);
  assign carryout = tick && (state_q == RUN) && at_term && !clear && !load;

  assign load_clamped = (64'(load_value) >= MODULUS) ? TERM_UP : load_value;

  always_comb begin
    step_val = count_q;
    if (FULL_RANGE) begin
      step_val = (dir == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    end else if (dir == DIR_DOWN) begin
      step_val = (count_q == '0) ? TERM_UP : count_q - WIDTH'(1);
    end else begin
      step_val = (count_q == TERM_UP) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    if (clear) begin
      state_d = RUN;
      count_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      state_d = RUN;
      count_d = load_clamped;
      done_d  = 1'b0;
    end else if (tick && (state_q == RUN)) begin
      if (at_term && (mode == MODE_ONESHOT)) begin
        // One-shot: hold at terminal instead of wrapping.
        state_d = HALT;
        done_d  = 1'b1;
      end else begin
        count_d = step_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count   = count_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter -- directed bench for mod_counter (WIDTH=4, MODULUS=10).
// Inputs change 1 time unit after each rising edge; the expected outputs for
// that cycle are pushed at the same time and a monitor compares them on the
// falling edge. Expected word: {state, done, carryout, count}.
module tb_mod_counter;
  import mod_counter_pkg::*;

  localparam int W  = 4;
  localparam int EW = W + 3;

  logic         clk;
  logic         rst;
  logic         enb;
  logic         dir;
  logic         mode;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         carryout;
  logic         done;
  state_e       state_o;

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  mod_counter #(
    .WIDTH   (W),
    .MODULUS (10)
`ifdef MOD_COUNTER_PRESCALE_EN
    ,
    .PRESCALE(3)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .dir        (dir),
    .mode       (mode),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .carryout   (carryout),
    .done       (done),
    .state_o    (state_o)
  );

  // ---------------- driver ----------------
  task automatic drive(input string tag,
                       input logic r, input logic e, input logic d,
                       input logic m, input logic c, input logic l,
                       input logic [W-1:0] lv,
                       input logic [W-1:0] ecnt, input logic eco,
                       input logic edn, input state_e est);
    @(posedge clk);
    #1;
    rst        = r;
    enb        = e;
    dir        = d;
    mode       = m;
    clear      = c;
    load       = l;
    load_value = lv;
    exp_q.push_back({logic'(est), edn, eco, ecnt});
    tag_q.push_back(tag);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] exp_v;
      logic [EW-1:0] act_v;
      string         tag;
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act_v = {logic'(state_o), done, carryout, count};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL %s @%0t: got state=%0b done=%0b carry=%0b count=%0d, want state=%0b done=%0b carry=%0b count=%0d",
                 tag, $time, act_v[EW-1], act_v[EW-2], act_v[EW-3], act_v[W-1:0],
                 exp_v[EW-1], exp_v[EW-2], exp_v[EW-3], exp_v[W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] up_seq[12];
    logic [W-1:0] dn_seq[4];
    logic [W-1:0] ps_seq[9];
    up_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
    dn_seq = '{4'd2, 4'd1, 4'd0, 4'd9};
    ps_seq = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};

    rst = 1'b1; enb = 1'b0; dir = 1'b0; mode = 1'b0;
    clear = 1'b0; load = 1'b0; load_value = '0;

    //      tag          r  e  d  m  c  l  lv   cnt co dn state
    drive("reset",      1, 0, 0, 0, 0, 0, 0,    0, 0, 0, RUN);

`ifdef MOD_COUNTER_PRESCALE_EN
    for (int i = 0; i < 9; i++)
      drive("ps_count", 0, 1, 0, 0, 0, 0, 0, ps_seq[i], 0, 0, RUN);
    drive("ps_idle",    0, 0, 0, 0, 0, 0, 0,    3, 0, 0, RUN);
    drive("ps_load",    0, 0, 0, 0, 0, 1, 9,    3, 0, 0, RUN);
    drive("ps_term0",   0, 1, 0, 0, 0, 0, 0,    9, 0, 0, RUN);
    drive("ps_term1",   0, 1, 0, 0, 0, 0, 0,    9, 0, 0, RUN);
    drive("ps_term2",   0, 1, 0, 0, 0, 0, 0,    9, 1, 0, RUN);
    drive("ps_wrap",    0, 0, 0, 0, 0, 0, 0,    0, 0, 0, RUN);
`else
    // Up count with wrap; carryout only while count is 9.
    for (int i = 0; i < 12; i++)
      drive("up_wrap",  0, 1, 0, 0, 0, 0, 0, up_seq[i], (i == 9), 0, RUN);

    // Down count from 2 through the 0 -> 9 wrap.
    drive("dn_load",    0, 0, 1, 0, 0, 1, 2,    2, 0, 0, RUN);
    for (int i = 0; i < 4; i++)
      drive("dn_wrap",  0, 1, 1, 0, 0, 0, 0, dn_seq[i], (i == 2), 0, RUN);

    // One-shot up from 7: halts at 9, ticks ignored, load restarts.
    drive("os_load",    0, 0, 0, 1, 0, 1, 7,    8, 0, 0, RUN);
    drive("os_7",       0, 1, 0, 1, 0, 0, 0,    7, 0, 0, RUN);
    drive("os_8",       0, 1, 0, 1, 0, 0, 0,    8, 0, 0, RUN);
    drive("os_9_tick",  0, 1, 0, 1, 0, 0, 0,    9, 1, 0, RUN);
    drive("os_halt",    0, 1, 0, 1, 0, 0, 0,    9, 0, 1, HALT);
    drive("os_halt_dn", 0, 1, 1, 1, 0, 0, 0,    9, 0, 1, HALT);
    drive("os_reload",  0, 1, 0, 1, 0, 1, 3,    9, 0, 1, HALT);

    // clear beats load beats tick; out-of-range load clamps to 9.
    drive("pri_all",    0, 1, 0, 0, 1, 1, 15,   3, 0, 0, RUN);
    drive("clamp_load", 0, 0, 0, 0, 0, 1, 15,   0, 0, 0, RUN);
    drive("load_gate",  0, 1, 0, 0, 0, 1, 15,   9, 0, 0, RUN);
    drive("clear_gate", 0, 1, 0, 0, 1, 0, 0,    9, 0, 0, RUN);

    // Reset while halted at 9, then counting resumes.
    drive("rst_load",   0, 0, 0, 1, 0, 1, 8,    0, 0, 0, RUN);
    drive("rst_8",      0, 1, 0, 1, 0, 0, 0,    8, 0, 0, RUN);
    drive("rst_9",      0, 1, 0, 1, 0, 0, 0,    9, 1, 0, RUN);
    drive("rst_in_halt",1, 1, 0, 1, 0, 0, 0,    9, 0, 1, HALT);
    drive("rst_after",  0, 1, 0, 0, 0, 0, 0,    0, 0, 0, RUN);
    drive("rst_resume", 0, 0, 0, 0, 0, 0, 0,    1, 0, 0, RUN);
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count register width in bits (legal range 2..32).
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH, count sequence length (legal range 2..2**WIDTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port enb, input, 1, count enable; one tick per cycle while high.
REQ-006 SHALL have port dir, input, 1, count direction (0 up, 1 down).
REQ-007 SHALL have port mode, input, 1, 0 wrap (free-run), 1 one-shot.
REQ-008 SHALL have port clear, input, 1, synchronous clear to 0.
REQ-009 SHALL have port load, input, 1, synchronous load of load_value.
REQ-010 SHALL have port load_value, input, WIDTH, value taken on load.
REQ-011 SHALL have port count, output, WIDTH, registered current count.
REQ-012 SHALL have port carryout, output, 1, combinational terminal pulse, cascadable into a downstream enb.
REQ-013 SHALL have port done, output, 1, registered; high while halted in one-shot.

Function
REQ-014 SHALL define an effective tick as enb high (gated by the prescaler when configured in).
REQ-015 SHALL treat MODULUS-1 as terminal when dir=0 and 0 as terminal when dir=1.
REQ-016 SHALL use FSM states RUN and HALT; RUN->HALT on tick at terminal with mode=1; HALT->RUN on clear or load; no other transitions.
REQ-017 SHALL apply priority rst > clear > load > tick in every cycle.
REQ-018 SHALL, in RUN on tick, step count by +1 (dir=0) or -1 (dir=1) modulo MODULUS; up from MODULUS-1 gives 0, down from 0 gives MODULUS-1.
REQ-019 SHALL, in one-shot mode, hold count at terminal instead of wrapping and set done the next cycle.
REQ-020 SHALL drive carryout = tick AND RUN AND count at terminal AND NOT clear AND NOT load, with zero latency.
REQ-021 SHALL ignore ticks in HALT; carryout stays 0 and count holds.
REQ-022 SHALL clamp load_value >= MODULUS to MODULUS-1 on load.
REQ-023 SHALL clear done on clear or load, with count updated the same cycle.
REQ-024 SHALL apply a change of dir or mode on the next tick without altering count.
REQ-025 SHALL, when MODULUS = 2**WIDTH, produce wrap via natural overflow with no extra compare.

Reset
REQ-026 SHALL, on rst high at a clk edge, set count=0, state=RUN, done=0, and prescaler=0; carryout follows as 0 while enb is low.
REQ-027 SHALL give rst mid-sequence, including in HALT, the same result as power-up reset, with no partial update.

Configuration
REQ-028 SHALL compile in, with macro MOD_COUNTER_PRESCALE_EN defined, parameter PRESCALE (default 4, legal >=1) and a prescaler so that a tick occurs on every PRESCALE-th enabled cycle.
REQ-029 SHALL reset the prescaler on rst, clear and load.
REQ-030 SHALL, without MOD_COUNTER_PRESCALE_EN, contain no prescaler logic and treat tick = enb.

Structure
REQ-031 SHALL place typedefs dir_e, mode_e and state_e (RUN, HALT) in a shared package mod_counter_pkg.
REQ-032 SHALL implement the prescaler as sub-module mod_counter_prescaler, instantiated only under MOD_COUNTER_PRESCALE_EN.
REQ-033 SHALL have elaboration-time checks reject illegal WIDTH, MODULUS or PRESCALE.

Verification (WIDTH=4, MODULUS=10, prescaler off unless stated)
REQ-034 SHALL cover up-wrap: rst, then enb=1, dir=0, mode=0 for 12 cycles -> count 0..9,0,1; carryout high only in the count=9 cycle.
REQ-035 SHALL cover down-wrap: load 2 with dir=1, then enb for 4 cycles -> count 2,1,0,9,8; carryout high at count=0.
REQ-036 SHALL cover one-shot: mode=1, up from 7, enb held -> count 8,9,9,9...; done=1 from the cycle after the 9-tick; carryout one cycle only; load 3 -> done=0, count=3, state RUN.
REQ-037 SHALL cover priority and clamp: clear, load=1 with load_value=15, and enb all in the same cycle -> count 0; then load 15 alone -> count 9, carryout 0 during the load.
REQ-038 SHALL cover reset mid-operation: rst in HALT with count=9 -> count 0, done 0, counting resumes on next enb.
REQ-039 SHALL cover prescale: with MOD_COUNTER_PRESCALE_EN and PRESCALE=3, enb=1 for 9 cycles -> count 3; carryout only on the tick cycle of a terminal count.
